// File: rtl/seq_normalizer_pkg.sv
// seq_normalizer_pkg
//   Shared types and constants for the sequential left-normalizer.
//   - state_e        : controller states (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH  : default operand width
//   - cnt_width()    : bits needed to hold a shift count of 0..w-1
package seq_normalizer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // ceil(log2(w)). At most w-1 shifts are ever applied, so this is the
  // smallest width that holds every reachable count. Callers use w >= 2.
  function automatic int cnt_width(input int w);
    int n;
    n = 0;
    while ((1 << n) < w) n++;
    return n;
  endfunction

endpackage

// File: rtl/seq_normalizer.sv
// seq_normalizer
//   Multi-cycle left-normalizer. An accepted operand is shifted left one bit
//   per cycle until its MSB is set; the result reports the normalized word,
//   the number of shifts applied (leading-zero count) and an all-zero flag.
//
// Ports
//   clk        : clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand offered
//   in_ready   : block can accept an operand (high only in IDLE)
//   in_data    : operand, WIDTH bits
//   out_valid  : result available (high only in DONE)
//   out_ready  : consumer takes the result
//   out_data   : normalized word, MSB set unless out_zero
//   out_shift  : number of left shifts applied, CNT_W bits
//   out_zero   : operand was all zeros
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Outputs are driven only from registers, so there is no
// combinational path from any input to in_ready or out_valid. While
// out_valid is high and out_ready low, all out_* signals hold steady.
module seq_normalizer
  import seq_normalizer_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;

  logic               in_is_zero;
  logic               in_msb_set;

  assign in_is_zero = (in_data == '0);
  assign in_msb_set = in_data[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = '0;
          if (in_is_zero) begin
            // Zero never enters SHIFT, so the loop always terminates.
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (in_msb_set) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        data_d = data_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        // The bit below the MSB becomes the new MSB on this edge.
        if (data_q[WIDTH-2]) state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_shift = cnt_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// tb_seq_normalizer
//   Directed and random operands for seq_normalizer (WIDTH = 8). Expected
//   results come from a leading-zero reference computed by scanning bits.
module tb_seq_normalizer;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_shift;
  logic          out_zero;

  int vectors;
  int miscompares;

  seq_normalizer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: leading zeros found by scanning from the MSB down.
  function automatic int ref_lz(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return (W - 1) - i;
    end
    return W;
  endfunction

  // ---------------- driver ----------------
  // Entered #1 after a rising edge with the DUT in IDLE. Offers one operand,
  // measures latency (accepting edge counts as 1), holds the result for
  // 'hold' cycles with in_valid noise, then takes it.
  task automatic do_op(input logic [W-1:0] din, input int hold);
    int          lz;
    int          lat;
    int          exp_lat;
    logic [W-1:0] exp_data;
    logic [CW-1:0] exp_shift;
    logic        exp_zero;

    lz = ref_lz(din);
    if (lz == W) begin
      exp_data  = '0;
      exp_shift = '0;
      exp_zero  = 1'b1;
      exp_lat   = 1;
    end else begin
      exp_data  = din << lz;
      exp_shift = CW'(lz);
      exp_zero  = 1'b0;
      exp_lat   = 1 + lz;
    end

    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 2 * W) begin
      check("in_ready_busy", in_ready, 0);
      in_valid = 1'(($urandom_range(0, 1)));
      in_data  = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;

    check("latency", lat, exp_lat);
    check("out_valid", out_valid, 1);
    check("out_data", out_data, exp_data);
    check("out_shift", out_shift, exp_shift);
    check("out_zero", out_zero, exp_zero);
    check("in_ready_done", in_ready, 0);

    repeat (hold) begin
      in_valid = 1'(($urandom_range(0, 1)));
      in_data  = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_shift", out_shift, exp_shift);
      check("hold_zero", out_zero, exp_zero);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_zero", out_zero, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] r;
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_shift", out_shift, 0);
    check("rst_out_zero", out_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(8'h80, 0);
    do_op(8'h13, 1);
    do_op(8'h01, 0);
    do_op(8'h00, 0);
    do_op(8'h40, 0);
    do_op(8'h05, 5);

    // Reset mid-SHIFT: 0x02 accepted, reset 3 cycles later
    in_valid = 1'b1;
    in_data  = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_shift_valid", out_valid, 0);
    check("rst_shift_cnt", out_shift, 0);
    check("rst_shift_in_ready", in_ready, 1);
    check("rst_shift_data", out_data, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    do_op(8'h40, 0);

    // Reset while a result is waiting
    in_valid = 1'b1;
    in_data  = 8'hC3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_done_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", out_valid, 0);
    check("rst_done_data", out_data, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle_valid", out_valid, 0);

    // Random operands, biased toward many leading zeros
    for (int n = 0; n < 40; n++) begin
      r = W'($urandom_range(0, 255));
      r = r >> $urandom_range(0, W - 1);
      do_op(r, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
